// File: rtl/mux_stream_pkg.sv
// Shared definitions for the N-to-1 registered stream multiplexer:
// mode encodings, output-stage states and channel-slice helper.
package mux_stream_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Low bit of channel `ch` inside a packed bus of `width`-bit channels.
  function automatic int unsigned ch_base(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/mux_stream_nx1_rr_arbiter.sv
// Round-robin arbiter: remembers the last granted channel and scans upward
// from the one after it, wrapping modulo NUM_CH.
module rr_arbiter
  import mux_stream_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant_onehot,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any
);

  localparam logic [SEL_W:0]   NCH     = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  logic [SEL_W-1:0] last_q, last_d;
  logic [SEL_W:0]   cand;

  // last_q <= NUM_CH-1 and k <= NUM_CH, so one conditional subtract wraps.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = {1'b0, last_q} + (SEL_W+1)'(k);
      if (cand >= NCH) cand = cand - NCH;
      if (!any && req[cand[SEL_W-1:0]]) begin
        any       = 1'b1;
        grant_idx = cand[SEL_W-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot
    assign grant_onehot[gi] = any && (grant_idx == SEL_W'(gi));
  end

  always_comb begin
    last_d = last_q;
    if (advance) last_d = grant_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= LAST_CH;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/mux_stream_nx1.sv
// Parametrised N-to-1 registered stream mux with valid/ready on every channel
// and a runtime choice of manual select or round-robin arbitration.
module mux_stream_nx1
  import mux_stream_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        select,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int SEL_SPAN = 1 << SEL_W;

  logic [WIDTH-1:0]    ch_data [NUM_CH];
  logic [SEL_SPAN-1:0] valid_ext;
  logic [NUM_CH-1:0]   man_onehot, rr_onehot, grant_onehot;
  logic [SEL_W-1:0]    rr_idx, grant_idx;
  logic                man_any, rr_any, grant_any, can_load, transfer;

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    assign ch_data[gi]    = in_data[ch_base(gi, WIDTH) +: WIDTH];
    assign man_onehot[gi] = man_any && (select == SEL_W'(gi));
  end

  // Unused select codes (non-power-of-2 NUM_CH) read a zero valid bit.
  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_CH-1:0]    = in_valid;
  end
  assign man_any = valid_ext[select];

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (in_valid),
    .advance      (transfer && (mode == MODE_RR)),
    .grant_onehot (rr_onehot),
    .grant_idx    (rr_idx),
    .any          (rr_any)
  );

  always_comb begin
    if (mode == MODE_RR) begin
      grant_any    = rr_any;
      grant_idx    = rr_idx;
      grant_onehot = rr_onehot;
    end else begin
      grant_any    = man_any;
      grant_idx    = select;
      grant_onehot = man_onehot;
    end
  end

  assign can_load = (state_q == ST_EMPTY) || out_ready;
  assign transfer = grant_any && can_load;
  assign in_ready = can_load ? grant_onehot : '0;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    if (transfer) begin
      state_d = ST_FULL;
      data_d  = ch_data[grant_idx];
      ch_d    = grant_idx;
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_mux_stream_nx1.sv
// Self-checking bench: table vectors, directed multi-cycle sequences and
// randomized traffic against a behavioural reference model.
module tb_mux_stream_nx1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  words [4];
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic        mode, out_ready, out_valid;
  logic [1:0]  select, out_ch;
  logic [7:0]  out_data;

  for (genvar gi = 0; gi < 4; gi++) begin : g_pack
    assign in_data[gi*8 +: 8] = words[gi];
  end

  mux_stream_nx1 #(.WIDTH(8), .NUM_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .select(select), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  logic [23:0] d3_in_data;
  logic [2:0]  d3_in_valid, d3_in_ready;
  logic        d3_mode, d3_out_ready, d3_out_valid;
  logic [1:0]  d3_select, d3_out_ch;
  logic [7:0]  d3_out_data;

  mux_stream_nx1 #(.WIDTH(8), .NUM_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_valid(d3_in_valid),
    .in_ready(d3_in_ready), .mode(d3_mode), .select(d3_select), .out_data(d3_out_data),
    .out_ch(d3_out_ch), .out_valid(d3_out_valid), .out_ready(d3_out_ready)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Reference model state: the word the output register should hold.
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_ch;
  int         m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ch    = 2'd0;
    m_last  = 3;
  endtask

  // Channel the rules say should be granted now, or -1 for none.
  function automatic int model_grant();
    if (mode) begin
      for (int k = 1; k <= 4; k++) begin
        if (in_valid[(m_last + k) % 4]) return (m_last + k) % 4;
      end
      return -1;
    end
    if (int'(select) < 4 && in_valid[select]) return int'(select);
    return -1;
  endfunction

  task automatic step(output logic [3:0] rdy_seen);
    int         g;
    logic       xfer;
    logic [3:0] er;
    #1;
    g    = model_grant();
    xfer = (g >= 0) && (!m_valid || out_ready);
    er   = xfer ? 4'(1 << g) : 4'b0000;
    rdy_seen = in_ready;
    chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    if (xfer) begin
      m_valid = 1'b1;
      m_data  = words[g];
      m_ch    = 2'(g);
      if (mode) m_last = g;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    cyc++;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_ch", 32'(out_ch), 32'(m_ch));
    end
    $display("cyc %0d mode=%0d sel=%0d in_valid=%b in_ready=%b out_ready=%b | out_valid=%b out_ch=%0d out_data=%h",
             cyc, mode, select, in_valid, rdy_seen, out_ready, out_valid, out_ch, out_data);
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [3:0] valid;
    logic [3:0] exp_ready;
    logic       exp_ov;
    logic [1:0] exp_ch;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       tbl [6];
  logic [3:0] r;

  initial begin
    rst_n = 1'b0;
    words[0] = 8'h10; words[1] = 8'h20; words[2] = 8'h30; words[3] = 8'h40;
    in_valid = 4'b0000; mode = 1'b0; select = 2'd0; out_ready = 1'b1;
    d3_in_data = {8'hC3, 8'hB2, 8'hA1};
    d3_in_valid = 3'b000; d3_mode = 1'b0; d3_select = 2'd0; d3_out_ready = 1'b1;
    model_reset();

    tbl[0] = '{2'd2, 4'b1111, 4'b0100, 1'b1, 2'd2, 8'h30};
    tbl[1] = '{2'd0, 4'b1111, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[2] = '{2'd3, 4'b1000, 4'b1000, 1'b1, 2'd3, 8'h40};
    tbl[3] = '{2'd1, 4'b1101, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[4] = '{2'd1, 4'b0010, 4'b0010, 1'b1, 2'd1, 8'h20};
    tbl[5] = '{2'd0, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00};

    // Reset values
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle after reset
    for (int i = 0; i < 2; i++) step(r);

    // Manual-mode table
    mode = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      select = tbl[i].sel; in_valid = tbl[i].valid;
      step(r);
      chk("tbl_ready", 32'(r), 32'(tbl[i].exp_ready));
      chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].exp_ov));
      if (tbl[i].exp_ov) begin
        chk("tbl_out_ch", 32'(out_ch), 32'(tbl[i].exp_ch));
        chk("tbl_out_data", 32'(out_data), 32'(tbl[i].exp_data));
      end
    end

    // Round-robin fairness: pointer still at reset value
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(r);
      chk("rr_fair_ch", 32'(out_ch), 32'(i % 4));
    end

    // Skip and wrap between ch0 and ch3
    in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step(r);
      chk("rr_wrap_ch", 32'(out_ch), (i % 2 == 0) ? 32'd0 : 32'd3);
    end

    // Backpressure with mode toggling while the word is held
    in_valid = 4'b1111; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mode = i[0];
      step(r);
      chk("bp_ready", 32'(r), 32'd0);
      chk("bp_data", 32'(out_data), 32'h40);
      chk("bp_ch", 32'(out_ch), 32'd3);
    end
    mode = 1'b1; out_ready = 1'b1;
    step(r);
    chk("bp_release_ready", 32'(r), 32'b0001);
    chk("bp_release_data", 32'(out_data), 32'h10);
    step(r);
    chk("bp_b2b_ch", 32'(out_ch), 32'd1);

    // Asynchronous reset while a word is held
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_ch", 32'(out_ch), 32'd0);
    model_reset();
    in_valid = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) step(r);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      mode      = 1'($urandom_range(0, 1));
      select    = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 4; c++) words[c] = 8'($urandom_range(0, 255));
      step(r);
    end

    // Three-channel instance: out-of-range select, then wrap at NUM_CH-1
    d3_mode = 1'b0; d3_select = 2'd3; d3_in_valid = 3'b111; d3_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("n3_badsel_ready", 32'(d3_in_ready), 32'd0);
      @(posedge clk); #1;
      chk("n3_badsel_valid", 32'(d3_out_valid), 32'd0);
      $display("n3 sel=3 in_ready=%b out_valid=%b", d3_in_ready, d3_out_valid);
    end
    d3_select = 2'd2;
    #1 chk("n3_sel2_ready", 32'(d3_in_ready), 32'b100);
    @(posedge clk); #1;
    chk("n3_sel2_ch", 32'(d3_out_ch), 32'd2);
    chk("n3_sel2_data", 32'(d3_out_data), 32'hC3);
    d3_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("n3_rr_ch", 32'(d3_out_ch), 32'(i % 3));
      $display("n3 rr out_ch=%0d out_data=%h", d3_out_ch, d3_out_data);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
